// File: rtl/npc_fetch_unit_if.sv
// Bus between the D-stage control-flow logic and the next-PC/fetch unit.
interface npc_fetch_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic              stall;
    logic              br_valid;
    logic [3:0]        br_type;
    logic              link_req;
    logic [31:0]       cmp_a;
    logic [31:0]       cmp_b;
    logic [31:0]       d_pc;
    logic [15:0]       imm16;
    logic [25:0]       idx26;
    logic [31:0]       jr_target;
    logic              exc_req;
    logic              eret_req;
    logic [31:0]       epc;
    logic [31:0]       f_pc;
    logic [31:0]       f_pc4;
    logic              redirect;
    logic              d_flush;
    logic              link_en;
    logic [31:0]       link_pc;
    logic              f_adel;
    logic [CNT_W-1:0]  redir_cnt;

    // Decode/hazard side: supplies control-flow requests, observes the fetch PC.
    modport master (
        output stall, br_valid, br_type, link_req, cmp_a, cmp_b, d_pc, imm16,
               idx26, jr_target, exc_req, eret_req, epc,
        input  f_pc, f_pc4, redirect, d_flush, link_en, link_pc, f_adel, redir_cnt
    );

    // Fetch unit side.
    modport slave (
        input  stall, br_valid, br_type, link_req, cmp_a, cmp_b, d_pc, imm16,
               idx26, jr_target, exc_req, eret_req, epc,
        output f_pc, f_pc4, redirect, d_flush, link_en, link_pc, f_adel, redir_cnt
    );
endinterface

// File: rtl/npc_fetch_unit.sv
// Next-PC stage: owns the fetch PC and resolves D-stage branches, jumps,
// exception/ERET redirects, link generation and a saturating redirect count.
module npc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC     = 32'h0000_4180,
    parameter bit          DELAY_SLOT  = 1'b1,
    parameter bit          CHECK_ALIGN = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    npc_fetch_unit_if.slave     bus
);
    localparam logic [3:0] BT_BEQ     = 4'd1;
    localparam logic [3:0] BT_BNE     = 4'd2;
    localparam logic [3:0] BT_BLEZ    = 4'd3;
    localparam logic [3:0] BT_BGTZ    = 4'd4;
    localparam logic [3:0] BT_BLTZ    = 4'd5;
    localparam logic [3:0] BT_BGEZ    = 4'd6;
    localparam logic [3:0] BT_J       = 4'd7;
    localparam logic [3:0] BT_JR      = 4'd8;
    localparam logic [3:0] BT_BLEZALC = 4'd9;

    logic [31:0]       f_pc_q, f_pc_d;
    logic [CNT_W-1:0]  redir_cnt_q, redir_cnt_d;

    logic              cond_c;
    logic              take_c;
    logic              redirect_c;
    logic [31:0]       d_pc4_c;
    logic [31:0]       target_c;

    // Branch condition and taken target for the D-stage instruction.
    always_comb begin
        cond_c   = 1'b0;
        take_c   = 1'b0;
        d_pc4_c  = bus.d_pc + 32'd4;
        target_c = d_pc4_c + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
        unique case (bus.br_type)
            BT_BEQ:             cond_c = (bus.cmp_a == bus.cmp_b);
            BT_BNE:             cond_c = (bus.cmp_a != bus.cmp_b);
            BT_BLEZ, BT_BLEZALC: cond_c = ($signed(bus.cmp_a) <= 32'sd0);
            BT_BGTZ:            cond_c = ($signed(bus.cmp_a) >  32'sd0);
            BT_BLTZ:            cond_c = ($signed(bus.cmp_a) <  32'sd0);
            BT_BGEZ:            cond_c = ($signed(bus.cmp_a) >= 32'sd0);
            default:            cond_c = 1'b0;
        endcase
        if (bus.br_type == BT_J) begin
            target_c = {d_pc4_c[31:28], bus.idx26, 2'b00};
        end else if (bus.br_type == BT_JR) begin
            target_c = bus.jr_target;
        end
        take_c = bus.br_valid &
                 ((bus.br_type == BT_J) | (bus.br_type == BT_JR) | cond_c);
        redirect_c = take_c & ~bus.stall & ~bus.exc_req & ~bus.eret_req;
    end

    // Next-PC priority: exception > ERET > stall hold > taken redirect > sequential.
    always_comb begin
        f_pc_d      = f_pc_q + 32'd4;
        redir_cnt_d = redir_cnt_q;
        if (bus.exc_req) begin
            f_pc_d = EXC_VEC;
        end else if (bus.eret_req) begin
            f_pc_d = bus.epc;
        end else if (bus.stall) begin
            f_pc_d = f_pc_q;
        end else if (take_c) begin
            f_pc_d = target_c;
        end
        if (redirect_c && (redir_cnt_q != {CNT_W{1'b1}})) begin
            redir_cnt_d = redir_cnt_q + CNT_W'(1);
        end
    end

    // PC and redirect-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pc_q      <= RESET_PC;
            redir_cnt_q <= '0;
        end else begin
            f_pc_q      <= f_pc_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    // Combinational fetch/link outputs.
    always_comb begin
        bus.f_pc      = f_pc_q;
        bus.f_pc4     = f_pc_q + 32'd4;
        bus.redirect  = redirect_c;
        bus.d_flush   = bus.exc_req | bus.eret_req | (~DELAY_SLOT & redirect_c);
        bus.link_en   = bus.br_valid &
                        (bus.link_req | ((bus.br_type == BT_BLEZALC) & cond_c));
        bus.link_pc   = DELAY_SLOT ? (bus.d_pc + 32'd8) : d_pc4_c;
        bus.f_adel    = CHECK_ALIGN & (f_pc_q[1:0] != 2'b00);
        bus.redir_cnt = redir_cnt_q;
    end
endmodule
